// File: rtl/spi_clk_gen.sv
// SPI serial clock and bit-strobe generator: divides clk_i down to spi_bus_clk (CPOL/CPHA aware)
// and issues registered sample/shift strobes for one transfer of len_i bits per accepted start.
module spi_clk_gen #(
  parameter int DLY       = 1,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 spi_bus_clk,
  output logic                 bit_en,
  output logic                 shift_en,
  output logic                 eot_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DivOne  = 1;
  localparam logic [CNT_WIDTH:0]   EdgeOne = 1;

  // DLY is kept so existing parameter overrides still elaborate; register updates carry no delay.
  if (DLY < 0) begin : g_dly_unused
  end

  state_e               state_q, state_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH:0]   edge_cnt_q, edge_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 bit_en_q, bit_en_d;
  logic                 shift_en_q, shift_en_d;
  logic                 eot_q, eot_d;
  logic                 tick;
  logic                 leading;
  logic                 last_edge;

  always_comb begin
    tick      = (div_cnt_q == div_q);
    leading   = ~edge_cnt_q[0];
    last_edge = (edge_cnt_q == ({len_q, 1'b0} - EdgeOne));

    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    len_d      = len_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    bit_en_d   = 1'b0;
    shift_en_d = 1'b0;
    eot_d      = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start_i && !abort_i && (len_i != '0)) begin
          state_d    = RUN;
          cpol_d     = cpol;
          cpha_d     = cpha;
          div_d      = div_i;
          len_d      = len_i;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          // CPHA=0 needs the first bit on the wire before the first leading edge
          shift_en_d = ~cpha;
        end
      end

      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          sclk_d  = cpol;
        end else if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EdgeOne;
          bit_en_d   = leading ^ cpha_q;
          shift_en_d = cpha_q ? leading : (!leading && !last_edge);
          if (last_edge) begin
            state_d = TAIL;
          end
        end else begin
          div_cnt_d = div_cnt_q + DivOne;
        end
      end

      TAIL: begin
        if (abort_i) begin
          state_d = IDLE;
          sclk_d  = cpol;
        end else begin
          sclk_d = cpol_q;
          if (tick) begin
            div_cnt_d = '0;
            state_d   = IDLE;
            eot_d     = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + DivOne;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = cpol;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      len_q      <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      bit_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      eot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      len_q      <= len_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      bit_en_q   <= bit_en_d;
      shift_en_q <= shift_en_d;
      eot_q      <= eot_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign spi_bus_clk = sclk_q;
  assign bit_en      = bit_en_q;
  assign shift_en    = shift_en_q;
  assign eot_o       = eot_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Bench for spi_clk_gen: directed mode/abort/reset cases plus randomized transfers, each cycle
// compared against an arithmetic model of edge times and strobe positions.
module tb_spi_clk_gen;

  logic       clk_i   = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       cpol    = 1'b0;
  logic       cpha    = 1'b0;
  logic [7:0] div_i   = '0;
  logic [5:0] len_i   = '0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       busy_o, spi_bus_clk, bit_en, shift_en, eot_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  spi_clk_gen #(.DLY(1), .DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cpol       (cpol),
    .cpha       (cpha),
    .div_i      (div_i),
    .len_i      (len_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .spi_bus_clk(spi_bus_clk),
    .bit_en     (bit_en),
    .shift_en   (shift_en),
    .eot_o      (eot_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_cnt(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic e_clk, input logic e_busy,
                         input logic e_bit, input logic e_shift, input logic e_eot);
    chk({tag, ".clk"},   spi_bus_clk, e_clk);
    chk({tag, ".busy"},  busy_o,      e_busy);
    chk({tag, ".bit"},   bit_en,      e_bit);
    chk({tag, ".shift"}, shift_en,    e_shift);
    chk({tag, ".eot"},   eot_o,       e_eot);
  endtask

  // Idle cycles: clock follows live cpol, nothing else asserted; clears any pending start/abort.
  task automatic idle_cycles(input int unsigned cyc, input string tag);
    for (int unsigned i = 0; i < cyc; i++) begin
      @(negedge clk_i);
      chk_all(tag, cpol, 1'b0, 1'b0, 1'b0, 1'b0);
      start_i = 1'b0;
      abort_i = 1'b0;
    end
  endtask

  // One transfer starting at the next posedge (edge T). Cycle n is the cycle after edge T+n.
  // abort_at != 0 raises abort so it is captured at edge T+abort_at.
  task automatic xfer(input logic cp, input logic ch, input int unsigned d, input int unsigned l,
                      input int unsigned abort_at, input bit scramble, input string tag);
    int unsigned hp   = d + 1;
    int unsigned nend = (2 * l + 1) * hp;
    int unsigned k;
    int unsigned nbit = 0;
    int unsigned nshift = 0;
    bit          tick_n;
    logic        e_clk, e_busy, e_bit, e_shift, e_eot;
    cpol    = cp;
    cpha    = ch;
    div_i   = 8'(d);
    len_i   = 6'(l);
    start_i = 1'b1;
    abort_i = 1'b0;
    @(posedge clk_i);
    for (int unsigned n = 0; n <= nend; n++) begin
      @(negedge clk_i);
      k      = n / hp;
      tick_n = (n != 0) && (n % hp == 0) && (k <= 2 * l);
      if (k > 2 * l) k = 2 * l;
      if (abort_at != 0 && n >= abort_at) begin
        e_clk = cp; e_busy = 1'b0; e_bit = 1'b0; e_shift = 1'b0; e_eot = 1'b0;
      end else begin
        e_busy  = (n < nend);
        e_eot   = (n == nend);
        e_clk   = cp ^ k[0];
        // edge k is a leading edge when k is odd
        e_bit   = tick_n && (ch ? (k % 2 == 0) : (k % 2 == 1));
        e_shift = ch ? (tick_n && (k % 2 == 1))
                     : ((n == 0) || (tick_n && (k % 2 == 0) && (k < 2 * l)));
      end
      chk_all(tag, e_clk, e_busy, e_bit, e_shift, e_eot);
      nbit   += (bit_en === 1'b1) ? 1 : 0;
      nshift += (shift_en === 1'b1) ? 1 : 0;

      start_i = 1'b0;
      abort_i = (abort_at != 0) && (n + 1 == abort_at);
      if (abort_at == 0 && n == 1) begin
        start_i = 1'b1;
        len_i   = 6'($urandom_range(1, 40));
      end
      if (scramble && abort_at == 0) begin
        if (n + 2 <= nend) begin
          cpol  = 1'($urandom);
          cpha  = 1'($urandom);
          div_i = 8'($urandom);
        end else if (n + 1 == nend) begin
          cpol = cp;
        end
      end
    end
    if (abort_at == 0) begin
      chk_cnt({tag, ".nbit"},   nbit,   l);
      chk_cnt({tag, ".nshift"}, nshift, l);
    end
  endtask

  initial begin
    int unsigned d, l, nend, ab;
    logic cp, ch;

    // Reset state (asserted from time 0; flops settle at the first posedge)
    repeat (2) @(negedge clk_i);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cpol    = 1'b1;
    rst_n_i = 1'b1;
    idle_cycles(2, "post_rst");

    xfer(1'b0, 1'b0, 1, 4, 0, 1'b0, "mode0");
    idle_cycles(2, "mode0_idle");

    xfer(1'b1, 1'b1, 0, 8, 0, 1'b0, "mode3");
    idle_cycles(2, "mode3_idle");

    xfer(1'b0, 1'b0, 1, 4, 5 * 2, 1'b0, "abort_m0");
    xfer(1'b1, 1'b1, 2, 3, 5 * 3, 1'b0, "abort_m3");
    idle_cycles(2, "abort_idle");

    cpol = 1'b0; len_i = '0; div_i = 8'd1; start_i = 1'b1;
    idle_cycles(3, "len0");
    len_i = 6'd5; start_i = 1'b1; abort_i = 1'b1;
    idle_cycles(3, "start_abort");

    xfer(1'b0, 1'b1, 2, 3, 0, 1'b0, "b2b_first");
    xfer(1'b1, 1'b0, 0, 5, 0, 1'b0, "b2b_second");
    idle_cycles(1, "b2b_idle");

    // Asynchronous reset while the clock is high and bit_en is asserted
    cpol = 1'b0; cpha = 1'b0; div_i = 8'd1; len_i = 6'd4; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_all("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    xfer(1'b0, 1'b0, 1, 4, 0, 1'b0, "mode0_after_rst");
    idle_cycles(1, "rst_idle");

    for (int unsigned t = 0; t < 16; t++) begin
      cp   = 1'($urandom);
      ch   = 1'($urandom);
      d    = $urandom_range(0, 3);
      l    = $urandom_range(1, 10);
      nend = (2 * l + 1) * (d + 1);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nend) : 0;
      xfer(cp, ch, d, l, ab, 1'b1, "rand");
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "rand_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
